// File: rtl/peripheral_bus_master_pkg.sv
// Shared types and constants for the CPU-side peripheral bus initiator.
// Holds the FSM encoding, the peripheral address map and the map lookup helper.
package peripheral_bus_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } bus_state_e;

  localparam logic [3:0]  KEYPAD_ADDR    = 4'h0;
  localparam logic [3:0]  DISPLAY_ADDR   = 4'h4;
  localparam logic [15:0] DEFAULT_RD_MAP = 16'h0001 << KEYPAD_ADDR;
  localparam logic [15:0] DEFAULT_WR_MAP = 16'h0001 << DISPLAY_ADDR;

  // Addresses beyond the 16-entry map are never mapped, whatever ADDR_W is.
  function automatic logic map_hit(logic [15:0] map, logic [31:0] addr);
    return (addr < 32'd16) && map[addr[3:0]];
  endfunction

endpackage

// File: rtl/peripheral_bus_master_if.sv
// Request/response channels plus the peripheral bus, viewed from the master
// (the initiator) or the slave side (CPU and peripheral_controller together).
interface peripheral_bus_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] din;
  logic              writeEnable;
  logic [DATA_W-1:0] dout;
  logic              busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, dout,
    output req_ready, resp_valid, resp_rdata, resp_err, address, din, writeEnable, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, address, din, writeEnable, busy
  );
endinterface

// File: rtl/peripheral_bus_master.sv
// Single-outstanding load/store initiator for peripheral_controller: checks the
// address map, drives one bus cycle and returns data or an error response.
module peripheral_bus_master
  import peripheral_bus_master_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 4,
  parameter int          READ_WAIT = 1,
  parameter logic [15:0] RD_MAP    = DEFAULT_RD_MAP,
  parameter logic [15:0] WR_MAP    = DEFAULT_WR_MAP
) (
  input  logic                     clk,
  input  logic                     reset,
  peripheral_bus_master_if.master  bus
);

  localparam logic [3:0] WAIT_INIT = READ_WAIT[3:0];

  bus_state_e state;
  logic [3:0] wait_cnt;
  logic       rd_hit;
  logic       wr_hit;

  assign rd_hit        = map_hit(RD_MAP, 32'(bus.req_addr));
  assign wr_hit        = map_hit(WR_MAP, 32'(bus.req_addr));
  assign bus.req_ready = (state == IDLE);

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register sees pre-edge values; the async reset branch must cover every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.address     <= '0;
      bus.din         <= '0;
      bus.writeEnable <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.resp_err    <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.address <= bus.req_addr;
            bus.busy    <= 1'b1;
            if (bus.req_write) bus.din <= bus.req_wdata;
            if (bus.req_write && wr_hit) begin
              state           <= WRITE;
              bus.writeEnable <= 1'b1;
            end else if (!bus.req_write && rd_hit) begin
              state    <= READ;
              wait_cnt <= WAIT_INIT;
            end else begin
              // Rejected access: answer straight away without touching the bus.
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end
          end
        end
        WRITE: begin
          state           <= RESP;
          bus.writeEnable <= 1'b0;
          bus.resp_valid  <= 1'b1;
          bus.resp_err    <= 1'b0;
          bus.resp_rdata  <= '0;
        end
        READ: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= bus.dout;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bus_master.sv
// Directed bench for peripheral_bus_master: stores, loads, map errors, response
// back-pressure, mid-transaction reset and the READ_WAIT extremes.
module tb_peripheral_bus_master;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   we_hi1 = 0;
  int   lat;

  always #5 clk = ~clk;

  peripheral_bus_master_if #(.DATA_W(32), .ADDR_W(4)) b1  ();
  peripheral_bus_master_if #(.DATA_W(32), .ADDR_W(4)) b0  ();
  peripheral_bus_master_if #(.DATA_W(32), .ADDR_W(4)) b3  ();
  peripheral_bus_master_if #(.DATA_W(32), .ADDR_W(4)) b15 ();

  peripheral_bus_master #(.READ_WAIT(1))  dut1  (.clk(clk), .reset(reset), .bus(b1));
  peripheral_bus_master #(.READ_WAIT(0))  dut0  (.clk(clk), .reset(reset), .bus(b0));
  peripheral_bus_master #(.READ_WAIT(3))  dut3  (.clk(clk), .reset(reset), .bus(b3));
  peripheral_bus_master #(.READ_WAIT(15)) dut15 (.clk(clk), .reset(reset), .bus(b15));

  always @(posedge clk) if (b1.writeEnable === 1'b1) we_hi1++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept1(input logic w, input logic [3:0] a, input logic [31:0] d);
    b1.req_valid = 1'b1;
    b1.req_write = w;
    b1.req_addr  = a;
    b1.req_wdata = d;
    @(posedge clk);
    #1 b1.req_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until resp_valid; 1 = first cycle after it.
  task automatic wait_resp1(output int l);
    l = 1;
    @(negedge clk);
    while (b1.resp_valid !== 1'b1 && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    b1.req_valid = 0; b1.req_write = 0; b1.req_addr = 0; b1.req_wdata = 0; b1.resp_ready = 0; b1.dout = 0;
    b0.req_valid = 0; b0.req_write = 0; b0.req_addr = 0; b0.req_wdata = 0; b0.resp_ready = 0; b0.dout = 0;
    b3.req_valid = 0; b3.req_write = 0; b3.req_addr = 0; b3.req_wdata = 0; b3.resp_ready = 0; b3.dout = 0;
    b15.req_valid = 0; b15.req_write = 0; b15.req_addr = 0; b15.req_wdata = 0; b15.resp_ready = 0; b15.dout = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_we",        32'(b1.writeEnable), 32'd0);
    check("rst_resp_valid", 32'(b1.resp_valid), 32'd0);
    check("rst_busy",      32'(b1.busy),        32'd0);
    check("rst_address",   32'(b1.address),     32'd0);
    check("rst_din",       b1.din,              32'd0);
    check("rst_rdata",     b1.resp_rdata,       32'd0);
    check("rst_err",       32'(b1.resp_err),    32'd0);
    check("rst_req_ready", 32'(b1.req_ready),   32'd1);

    // 1: store A5 to display
    b1.resp_ready = 1'b1;
    accept1(1'b1, 4'h4, 32'h0000_00A5);
    @(negedge clk);
    check("st_we",        32'(b1.writeEnable), 32'd1);
    check("st_address",   32'(b1.address),     32'd4);
    check("st_din",       b1.din,              32'hA5);
    check("st_no_resp",   32'(b1.resp_valid),  32'd0);
    check("st_req_ready", 32'(b1.req_ready),   32'd0);
    @(negedge clk);
    check("st_we_drop",   32'(b1.writeEnable), 32'd0);
    check("st_resp",      32'(b1.resp_valid),  32'd1);
    check("st_err",       32'(b1.resp_err),    32'd0);
    check("st_rdata",     b1.resp_rdata,       32'd0);
    @(negedge clk);
    check("st_idle",      32'(b1.resp_valid),  32'd0);
    check("st_busy",      32'(b1.busy),        32'd0);
    check("st_we_once",   32'(we_hi1),         32'd1);

    // 2: load keypad, READ_WAIT=1
    b1.resp_ready = 1'b0;
    accept1(1'b0, 4'h0, 32'hFFFF_FFFF);
    b1.dout = 32'h0000_000B;
    wait_resp1(lat);
    check("ld_latency", 32'(lat),          32'd3);
    check("ld_rdata",   b1.resp_rdata,     32'hB);
    check("ld_err",     32'(b1.resp_err),  32'd0);
    check("ld_din",     b1.din,            32'hA5);
    check("ld_address", 32'(b1.address),   32'd0);
    check("ld_no_we",   32'(we_hi1),       32'd1);
    b1.resp_ready = 1'b1;
    @(negedge clk);
    check("ld_done", 32'(b1.resp_valid), 32'd0);

    // 3: wrong-direction and unmapped accesses
    accept1(1'b0, 4'h4, 32'h0);
    wait_resp1(lat);
    check("e1_latency", 32'(lat),         32'd1);
    check("e1_err",     32'(b1.resp_err), 32'd1);
    check("e1_rdata",   b1.resp_rdata,    32'd0);
    check("e1_address", 32'(b1.address),  32'd4);
    @(negedge clk);
    accept1(1'b1, 4'h0, 32'h0000_1234);
    wait_resp1(lat);
    check("e2_latency", 32'(lat),         32'd1);
    check("e2_err",     32'(b1.resp_err), 32'd1);
    check("e2_address", 32'(b1.address),  32'd0);
    check("e2_din",     b1.din,           32'h1234);
    @(negedge clk);
    accept1(1'b1, 4'h9, 32'h0000_DEAD);
    wait_resp1(lat);
    check("e3_latency", 32'(lat),         32'd1);
    check("e3_err",     32'(b1.resp_err), 32'd1);
    check("e3_rdata",   b1.resp_rdata,    32'd0);
    check("e3_address", 32'(b1.address),  32'd9);
    @(negedge clk);
    check("e_no_we",    32'(we_hi1),      32'd1);

    // 4: response back-pressure with a second request waiting
    b1.resp_ready = 1'b0;
    accept1(1'b0, 4'h0, 32'h0);
    b1.dout = 32'h0000_0077;
    wait_resp1(lat);
    check("bp_latency", 32'(lat), 32'd3);
    b1.dout      = 32'h0;
    b1.req_valid = 1'b1;
    b1.req_write = 1'b1;
    b1.req_addr  = 4'h4;
    b1.req_wdata = 32'h0000_0055;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_ready", 32'(b1.req_ready),  32'd0);
      check("bp_resp",      32'(b1.resp_valid), 32'd1);
      check("bp_rdata",     b1.resp_rdata,      32'h77);
    end
    check("bp_din_hold", b1.din,       32'hDEAD);
    check("bp_no_we",    32'(we_hi1),  32'd1);
    b1.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_after", 32'(b1.req_ready), 32'd1);
    @(posedge clk);
    #1 b1.req_valid = 1'b0;
    @(negedge clk);
    check("bp2_we",      32'(b1.writeEnable), 32'd1);
    check("bp2_din",     b1.din,              32'h55);
    check("bp2_address", 32'(b1.address),     32'd4);
    @(negedge clk);
    check("bp2_resp",    32'(b1.resp_valid),  32'd1);
    check("bp2_err",     32'(b1.resp_err),    32'd0);
    @(negedge clk);
    check("bp2_idle",    32'(b1.busy),        32'd0);
    check("bp2_we_cnt",  32'(we_hi1),         32'd2);

    // 5: reset during READ and during WRITE (READ_WAIT=3 instance)
    b3.req_valid = 1'b1; b3.req_write = 1'b0; b3.req_addr = 4'h0;
    @(posedge clk);
    #1 b3.req_valid = 1'b0;
    @(negedge clk);
    check("rr_busy_read", 32'(b3.busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rr_busy",  32'(b3.busy),        32'd0);
    check("rr_resp",  32'(b3.resp_valid),  32'd0);
    check("rr_we",    32'(b3.writeEnable), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    b3.req_valid = 1'b1; b3.req_write = 1'b1; b3.req_addr = 4'h4; b3.req_wdata = 32'h0000_0099;
    @(posedge clk);
    #1 b3.req_valid = 1'b0;
    @(negedge clk);
    check("rw_we_before", 32'(b3.writeEnable), 32'd1);
    reset = 1'b1;
    #1;
    check("rw_we",      32'(b3.writeEnable), 32'd0);
    check("rw_busy",    32'(b3.busy),        32'd0);
    check("rw_resp",    32'(b3.resp_valid),  32'd0);
    check("rw_address", 32'(b3.address),     32'd0);
    @(negedge clk);
    reset = 1'b0;
    b3.resp_ready = 1'b1;
    b3.req_valid = 1'b1; b3.req_write = 1'b0; b3.req_addr = 4'h0;
    @(posedge clk);
    #1 b3.req_valid = 1'b0;
    b3.dout = 32'h0000_0033;
    lat = 1;
    @(negedge clk);
    while (b3.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("r3_latency", 32'(lat),         32'd5);
    check("r3_rdata",   b3.resp_rdata,    32'h33);
    check("r3_err",     32'(b3.resp_err), 32'd0);
    @(negedge clk);
    check("r3_idle",    32'(b3.busy),     32'd0);

    // 6: READ_WAIT extremes
    b0.resp_ready = 1'b1;
    b0.req_valid = 1'b1; b0.req_write = 1'b0; b0.req_addr = 4'h0;
    @(posedge clk);
    #1 b0.req_valid = 1'b0;
    b0.dout = 32'h0000_00C0;
    lat = 1;
    @(negedge clk);
    while (b0.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w0_latency", 32'(lat),      32'd2);
    check("w0_rdata",   b0.resp_rdata, 32'hC0);

    b15.resp_ready = 1'b1;
    b15.req_valid = 1'b1; b15.req_write = 1'b0; b15.req_addr = 4'h0;
    @(posedge clk);
    #1 b15.req_valid = 1'b0;
    b15.dout = 32'h0000_0F15;
    lat = 1;
    @(negedge clk);
    while (b15.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w15_latency", 32'(lat),       32'd17);
    check("w15_rdata",   b15.resp_rdata, 32'hF15);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
